// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT pipeline constants and complex sample type
package fft_pkg;
    localparam int FFT_N     = 32;
    localparam int FFT_LOG2N = 5;
    localparam int SAMPLE_W  = 16;
    localparam int OUT_W     = 17;

    typedef struct packed {
        logic signed [OUT_W-1:0] re;
        logic signed [OUT_W-1:0] im;
    } cplx_t;
endpackage

// File: rtl/sdf_delay_line.sv
// rtl/sdf_delay_line.sv - enabled shift-register delay line, head read combinationally
module sdf_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (en) begin
            mem[0] <= din;
            for (int k = 1; k < DEPTH; k++) mem[k] <= mem[k-1];
        end
    end

    assign head = mem[DEPTH-1];
endmodule

// File: rtl/r2sdf_last_stage.sv
// rtl/r2sdf_last_stage.sv - final unity-twiddle R2SDF butterfly feeding the bit-reversal sorter
module r2sdf_last_stage
    import fft_pkg::*;
#(
    parameter int IN_W      = SAMPLE_W,
    parameter int DELAY     = 1,
    parameter int FRAME_LEN = FFT_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] in_r,
    input  logic signed [IN_W-1:0] in_i,
    output logic                   out_valid,
    output logic signed [IN_W:0]   out_r,
    output logic signed [IN_W:0]   out_i,
    output logic                   out_sof,
    output logic                   start_sorting
);
    localparam int OW    = IN_W + 1;
    localparam int PH_W  = $clog2(2 * DELAY);
    localparam int IDX_W = $clog2(FRAME_LEN);

    logic [PH_W-1:0]  ph;
    logic [IDX_W-1:0] idx;
    logic             primed;
    logic             phase_b;
    logic             emit;

    logic signed [OW-1:0] x_r, x_i, fb_r, fb_i;
    logic signed [OW-1:0] sum_r, sum_i, diff_r, diff_i;
    logic signed [OW-1:0] cand_r, cand_i;
    logic [2*OW-1:0]      head, push;

    assign x_r = {in_r[IN_W-1], in_r};
    assign x_i = {in_i[IN_W-1], in_i};
    assign fb_r = head[2*OW-1:OW];
    assign fb_i = head[OW-1:0];

    assign sum_r  = fb_r + x_r;
    assign sum_i  = fb_i + x_i;
    assign diff_r = fb_r - x_r;
    assign diff_i = fb_i - x_i;

    assign phase_b = (ph >= PH_W'(DELAY));
    assign push    = phase_b ? {diff_r, diff_i} : {x_r, x_i};
    assign cand_r  = phase_b ? sum_r : fb_r;
    assign cand_i  = phase_b ? sum_i : fb_i;
    // Phase-A candidates are stale zeros until the first difference has been stored.
    assign emit    = in_valid && (primed || phase_b);

    sdf_delay_line #(.DEPTH(DELAY), .W(2*OW)) u_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (in_valid),
        .din  (push),
        .head (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph            <= '0;
            idx           <= '0;
            primed        <= 1'b0;
            out_valid     <= 1'b0;
            out_r         <= '0;
            out_i         <= '0;
            out_sof       <= 1'b0;
            start_sorting <= 1'b0;
        end else begin
            out_valid <= emit;
            out_sof   <= emit && (idx == '0);
            if (in_valid) begin
                ph <= ph + 1'b1;
                if (phase_b) primed <= 1'b1;
            end
            if (emit) begin
                out_r         <= cand_r;
                out_i         <= cand_i;
                start_sorting <= 1'b1;
                idx           <= (idx == IDX_W'(FRAME_LEN - 1)) ? '0 : idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_r2sdf_last_stage.sv
// tb/tb_r2sdf_last_stage.sv - scoreboard bench for r2sdf_last_stage at DELAY=1 and DELAY=4
module tb_r2sdf_last_stage;
    logic clk = 1'b0;
    logic rst;
    logic in_valid1, in_valid4;
    logic signed [15:0] in_r, in_i;
    logic out_valid1, out_sof1, ss1;
    logic out_valid4, out_sof4, ss4;
    logic signed [16:0] out_r1, out_i1, out_r4, out_i4;

    typedef struct {
        int r;
        int i;
        bit sof;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   total  = 0;
    int   passed = 0;
    logic acc1   = 1'b0;
    logic acc4   = 1'b0;

    always #5 clk = ~clk;

    r2sdf_last_stage #(.IN_W(16), .DELAY(1), .FRAME_LEN(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_r(in_r), .in_i(in_i),
        .out_valid(out_valid1), .out_r(out_r1), .out_i(out_i1),
        .out_sof(out_sof1), .start_sorting(ss1)
    );

    r2sdf_last_stage #(.IN_W(16), .DELAY(4), .FRAME_LEN(32)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_r(in_r), .in_i(in_i),
        .out_valid(out_valid4), .out_r(out_r4), .out_i(out_i4),
        .out_sof(out_sof4), .start_sorting(ss4)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        acc1 <= in_valid1 && !rst;
        acc4 <= in_valid4 && !rst;
    end

    always @(negedge clk) begin
        exp_t e;
        if (out_valid1) begin
            chk("d1_valid_after_accept", int'(acc1), 1);
            if (q1.size() == 0) begin
                chk("d1_unexpected_output", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("d1_out_r", int'(out_r1), e.r);
                chk("d1_out_i", int'(out_i1), e.i);
                chk("d1_out_sof", int'(out_sof1), int'(e.sof));
                chk("d1_start_sorting", int'(ss1), 1);
            end
        end
        if (out_valid4) begin
            chk("d4_valid_after_accept", int'(acc4), 1);
            if (q4.size() == 0) begin
                chk("d4_unexpected_output", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("d4_out_r", int'(out_r4), e.r);
                chk("d4_out_i", int'(out_i4), e.i);
                chk("d4_out_sof", int'(out_sof4), int'(e.sof));
                chk("d4_start_sorting", int'(ss4), 1);
            end
        end
    end

    task automatic exp1(input int r, input int i, input bit sof);
        q1.push_back('{r, i, sof});
    endtask

    task automatic exp4(input int r, input int i, input bit sof);
        q4.push_back('{r, i, sof});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_d1_valid"}, int'(out_valid1), 0);
        chk({tag, "_d1_r"}, int'(out_r1), 0);
        chk({tag, "_d1_i"}, int'(out_i1), 0);
        chk({tag, "_d1_sof"}, int'(out_sof1), 0);
        chk({tag, "_d1_ss"}, int'(ss1), 0);
        chk({tag, "_d4_valid"}, int'(out_valid4), 0);
        chk({tag, "_d4_r"}, int'(out_r4), 0);
        chk({tag, "_d4_ss"}, int'(ss4), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero(tag);
        rst = 1'b0;
    endtask

    task automatic send(input bit d4, input int r, input int i);
        in_r = 16'(r);
        in_i = 16'(i);
        if (d4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic scenario1(input int gap);
        exp1(130, 0, 1'b1);
        exp1(70, 0, 1'b0);
        send(1'b0, 100, 0); idle(gap);
        send(1'b0, 30, 0);  idle(gap);
        send(1'b0, 0, 0);
        idle(2);
    endtask

    initial begin
        rst = 1'b1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        in_r = '0;
        in_i = '0;
        #1;
        idle(2);
        do_reset("reset0");

        scenario1(0);

        do_reset("reset1");
        exp1(65534, -1, 1'b1);
        exp1(0, -65535, 1'b0);
        send(1'b0, 32767, -32768);
        send(1'b0, 32767, 32767);
        send(1'b0, 0, 0);
        idle(2);

        do_reset("reset2");
        scenario1(3);

        do_reset("reset3");
        for (int k = 0; k < 33; k++) exp1(0, 0, (k == 0) || (k == 32));
        for (int k = 0; k < 34; k++) send(1'b0, 0, 0);
        idle(2);

        do_reset("reset4");
        exp1(30, 0, 1'b1);
        exp1(-10, 0, 1'b0);
        exp1(70, 0, 1'b0);
        exp1(-10, 0, 1'b0);
        for (int k = 1; k <= 5; k++) send(1'b0, 10 * k, 0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        scenario1(0);

        do_reset("reset5");
        exp4(6, 0, 1'b1);
        exp4(8, 0, 1'b0);
        exp4(10, 0, 1'b0);
        exp4(12, 0, 1'b0);
        for (int k = 0; k < 4; k++) exp4(-4, 0, 1'b0);
        for (int k = 1; k <= 8; k++) send(1'b1, k, 0);
        for (int k = 0; k < 4; k++) send(1'b1, 0, 0);
        idle(3);

        chk("d1_outputs_missing", q1.size(), 0);
        chk("d4_outputs_missing", q4.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
